// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-type encodings and transmitter FSM states.
// Imported by the transmitter, its parity generator and the future RX checker.
package uart_pkg;

   typedef logic [1:0] parity_t;

   localparam parity_t PAR_NONE = 2'b00;
   localparam parity_t PAR_ODD  = 2'b01;
   localparam parity_t PAR_EVEN = 2'b10;
   localparam parity_t PAR_MARK = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   function automatic logic parity_enabled(input parity_t ptype);
      return ptype != PAR_NONE;
   endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for a DATA_WIDTH-bit word; shared by TX and RX paths.
// Disabled parity yields 0, mark parity yields a constant 1.
module uart_parity_gen
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            parity_type,
   output logic                  parity
);

   always_comb begin
      parity = 1'b0;
      case (parity_type)
         PAR_NONE: parity = 1'b0;
         PAR_ODD:  parity = ~(^data);
         PAR_EVEN: parity = ^data;
         PAR_MARK: parity = 1'b1;
         default:  parity = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional
// parity, STOP_BITS stop bits. Data, parity type and parity are latched per frame.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [1:0]            parity_type,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  parity_bit
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

   uart_state_t           r_state,  w_state_nxt;
   logic [BAUD_W-1:0]     r_baud,   w_baud_nxt;
   logic [IDX_W-1:0]      r_idx,    w_idx_nxt;
   logic [DATA_WIDTH-1:0] r_shift,  w_shift_nxt;
   parity_t               r_ptype,  w_ptype_nxt;
   logic                  r_parity, w_parity_nxt;
   logic                  r_tx,     w_tx_nxt;
   logic                  r_ready,  w_ready_nxt;
   logic                  r_busy,   w_busy_nxt;

   logic                  w_par_calc;
   logic                  w_accept;
   logic                  w_wrap;

   uart_parity_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity_gen (
      .data        (tx_data),
      .parity_type (parity_type),
      .parity      (w_par_calc)
   );

   assign w_accept = tx_valid & r_ready;
   assign w_wrap   = (r_baud == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_ptype  <= PAR_NONE;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_idx    <= w_idx_nxt;
         r_shift  <= w_shift_nxt;
         r_ptype  <= w_ptype_nxt;
         r_parity <= w_parity_nxt;
         r_tx     <= w_tx_nxt;
         r_ready  <= w_ready_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // r_idx counts data bits in DATA and stop bits in STOP.
   always_comb begin
      w_state_nxt  = r_state;
      w_baud_nxt   = r_baud;
      w_idx_nxt    = r_idx;
      w_shift_nxt  = r_shift;
      w_ptype_nxt  = r_ptype;
      w_parity_nxt = r_parity;

      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            w_idx_nxt  = '0;
            if (w_accept) begin
               w_state_nxt  = START;
               w_shift_nxt  = tx_data;
               w_ptype_nxt  = parity_type;
               w_parity_nxt = w_par_calc;
            end
         end
         START: begin
            w_baud_nxt = w_wrap ? '0 : r_baud + BAUD_W'(1);
            if (w_wrap) begin
               w_state_nxt = DATA;
               w_idx_nxt   = '0;
            end
         end
         DATA: begin
            w_baud_nxt = w_wrap ? '0 : r_baud + BAUD_W'(1);
            if (w_wrap) begin
               w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
               if (r_idx == DATA_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = parity_enabled(r_ptype) ? PARITY : STOP;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            w_baud_nxt = w_wrap ? '0 : r_baud + BAUD_W'(1);
            if (w_wrap) begin
               w_state_nxt = STOP;
               w_idx_nxt   = '0;
            end
         end
         STOP: begin
            w_baud_nxt = w_wrap ? '0 : r_baud + BAUD_W'(1);
            if (w_wrap) begin
               if (r_idx == STOP_LAST) begin
                  w_idx_nxt = '0;
                  if (w_accept) begin
                     w_state_nxt  = START;
                     w_shift_nxt  = tx_data;
                     w_ptype_nxt  = parity_type;
                     w_parity_nxt = w_par_calc;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_baud_nxt  = '0;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up
   // with the state they describe (start bit appears the clock after accept).
   always_comb begin
      w_tx_nxt    = 1'b1;
      w_busy_nxt  = (w_state_nxt != IDLE);
      w_ready_nxt = 1'b0;
      case (w_state_nxt)
         IDLE: begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
         end
         START:  w_tx_nxt = 1'b0;
         DATA:   w_tx_nxt = w_shift_nxt[0];
         PARITY: w_tx_nxt = w_parity_nxt;
         STOP: begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = (w_idx_nxt == STOP_LAST) && (w_baud_nxt == BAUD_LAST);
         end
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign tx         = r_tx;
   assign tx_ready   = r_ready;
   assign tx_busy    = r_busy;
   assign parity_bit = r_parity;

endmodule
